// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, frame shape and the default
// oversample divider used by both the RX sampler and the TX bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int FRAME_BITS      = 10;
  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_CLK_DIV = 16;

  // High-to-low transition between two successive line samples.
  function automatic logic is_fall(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample divider: counts 0..CLK_DIV-1 while enabled and pulses tick on the
// terminal count. Shared with the transmitter, where tick drives bit advance.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] TC = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  assign tick = en && !clr && (cnt == TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TC) ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with a one-byte holding register and sticky
// framing/overrun flags.
//
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | timing to mid start bit to reject glitches
//   RX_DATA  | sampling 8 data bits at mid-bit, LSB first
//   RX_STOP  | sampling the stop bit, then load or flag
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

  rx_state_t  state;
  logic       rxd_m, rxd_s, rxd_p;
  logic [3:0] s_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  // Divider is parked at zero in IDLE so the first tick lands CLK_DIV clk
  // after the start edge is seen.
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state != RX_IDLE),
    .clr   (state == RX_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rd)
        valid <= 1'b0;
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (tick)
        s_cnt <= s_cnt + 4'd1;

      // Flag sets below come after the clears so a same-clk event wins.
      case (state)
        RX_IDLE: begin
          if (is_fall(rxd_p, rxd_s)) begin
            state <= RX_START;
            busy  <= 1'b1;
            s_cnt <= '0;
          end
        end
        RX_START: begin
          if (tick && s_cnt == S_MID) begin
            s_cnt <= '0;
            if (rxd_s) begin
              state <= RX_IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= '0;
              state   <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tick && s_cnt == S_LAST) begin
            shift   <= {rxd_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == B_LAST) begin
              state <= RX_STOP;
              s_cnt <= '0;
            end
          end
        end
        RX_STOP: begin
          if (tick && s_cnt == S_LAST) begin
            state <= RX_IDLE;
            busy  <= 1'b0;
            s_cnt <= '0;
            if (rxd_s) begin
              data  <= shift;
              valid <= 1'b1;
              if (valid && !rd)
                overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= RX_IDLE;
          busy  <= 1'b0;
          s_cnt <= '0;
        end
      endcase
    end
  end

endmodule
